// File: rtl/adder_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : adder_arb_pkg
//  Brief    : Shared types and constants for the pipelined-adder arbiter:
//             FSM state encoding, default parameter values, clog2 helper.
//  Revision : 1.0 - initial release
// ============================================================================
package adder_arb_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_N_REQ = 4;
    localparam int DEF_DEPTH = 4;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } arb_state_e;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adder_pipe_arbiter_tag_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tag_fifo
//  Brief    : In-order owner-tag FIFO, DEPTH entries of TAG_W bits, with
//             push/pop/clear and count/full/empty status.
//  Revision : 1.0 - initial release
// ============================================================================
module tag_fifo
    import adder_arb_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int TAG_W = 2,
    parameter int CNT_W = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             clear_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic [TAG_W-1:0] tag_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int                PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0]  LAST  = PTR_W'(DEPTH - 1);

    logic [TAG_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic w_do_push;
    logic w_do_pop;

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign w_do_push = push_i && (!full_o || pop_i);
    assign w_do_pop  = pop_i && !empty_o;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign tag_o   = mem_q[rd_ptr_q];

    // Storage array; contents are meaningless while count is zero, so no reset.
    always_ff @(posedge clk) begin
        if (w_do_push && !clear_i) begin
            mem_q[wr_ptr_q] <= tag_i;
        end
    end

    // Pointer and occupancy tracking; clear wins over push/pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_do_push) begin
                wr_ptr_q <= (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
            end
            if (w_do_pop) begin
                rd_ptr_q <= (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!w_do_push && w_do_pop) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/adder_pipe_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : adder_pipe_arbiter
//  Brief    : Round-robin arbiter sharing one DEPTH-stage stallable pipeline
//             adder among N_REQ requesters. Owner tags of in-flight ops are
//             kept in order so each result returns to its requester. Drain
//             freezes issue until empty; flush refreshes the whole pipe.
//             Optional macro ADDER_ARB_STATS_EN adds per-requester grant
//             counters and a flush counter (16-bit, saturating).
//  Revision : 1.0 - initial release
// ============================================================================
module adder_pipe_arbiter
    import adder_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N_REQ = DEF_N_REQ,
    parameter int DEPTH = DEF_DEPTH,
    parameter int TAG_W = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    input  logic [N_REQ-1:0]       req_cin,
    output logic [N_REQ-1:0]       resp_valid,
    input  logic [N_REQ-1:0]       resp_ready,
    output logic [WIDTH-1:0]       resp_sum,
    output logic                   resp_cout,
    input  logic                   drain_req,
    input  logic                   flush_req,
    output logic                   busy,
`ifdef ADDER_ARB_STATS_EN
    output logic [N_REQ*16-1:0]    grant_cnt,
    output logic [15:0]            flush_cnt,
`endif
    output logic                   add_valid_in,
    output logic [WIDTH-1:0]       add_a,
    output logic [WIDTH-1:0]       add_b,
    output logic                   add_cin,
    output logic [DEPTH-1:0]       add_pause,
    output logic [DEPTH-1:0]       add_refresh,
    output logic                   add_out_allow,
    input  logic                   add_valid_out,
    input  logic [WIDTH-1:0]       add_sum,
    input  logic                   add_cout
);

    localparam int CNT_W = clog2(DEPTH + 1);

    arb_state_e       state_q, state_d;
    logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [TAG_W-1:0] w_head_tag;
    logic [CNT_W-1:0] w_count;
    logic             w_full;
    logic             w_empty;
    logic             w_have;
    logic [N_REQ-1:0] w_head_oh;
    logic             w_head_ready;
    logic             w_out_allow;
    logic             w_pop;
    logic             w_issue_ok;
    logic             w_win_found;
    logic [TAG_W-1:0] w_win_idx;
    logic             w_grant;
    logic [WIDTH-1:0] w_add_a;
    logic [WIDTH-1:0] w_add_b;
    logic             w_add_cin;

    // ---------------------------------------------------------------- return
    assign w_have       = !w_empty;
    assign w_head_oh    = N_REQ'(1) << w_head_tag;
    assign w_head_ready = |(resp_ready & w_head_oh);
    assign w_out_allow  = w_have ? w_head_ready : 1'b1;
    assign w_pop        = add_valid_out && w_out_allow;

    // ----------------------------------------------------------------- issue
    assign w_issue_ok = (state_q == RUN) && (!w_full || w_pop) && !flush_req;
    assign w_grant    = rst && w_issue_ok && w_win_found;

    // Round-robin search: first valid requester at or after rr_ptr, with wrap.
    always_comb begin
        logic [TAG_W:0] idx;
        w_win_found = 1'b0;
        w_win_idx   = '0;
        idx         = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = {1'b0, rr_ptr_q} + (TAG_W+1)'(k);
            if (idx >= (TAG_W+1)'(N_REQ)) begin
                idx = idx - (TAG_W+1)'(N_REQ);
            end
            if (!w_win_found && |(req_valid & (N_REQ'(1) << idx[TAG_W-1:0]))) begin
                w_win_found = 1'b1;
                w_win_idx   = idx[TAG_W-1:0];
            end
        end
    end

    // Operand mux from the winning slot; zero when nothing is issued.
    always_comb begin
        w_add_a   = '0;
        w_add_b   = '0;
        w_add_cin = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant && (w_win_idx == TAG_W'(i))) begin
                w_add_a   = req_a[i*WIDTH +: WIDTH];
                w_add_b   = req_b[i*WIDTH +: WIDTH];
                w_add_cin = req_cin[i];
            end
        end
    end

    // Pointer advances past the winner only when a grant actually happens.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (w_grant) begin
            rr_ptr_d = (w_win_idx == TAG_W'(N_REQ - 1)) ? '0 : w_win_idx + 1'b1;
        end
    end

    // Next-state logic; flush always takes priority over drain.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (flush_req) begin
                    state_d = FLUSH;
                end else if (drain_req) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (flush_req) begin
                    state_d = FLUSH;
                end else if (w_empty) begin
                    state_d = RUN;
                end
            end
            FLUSH:   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // State and round-robin pointer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= RUN;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    tag_fifo #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W),
        .CNT_W (CNT_W)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_grant),
        .pop_i   (w_pop),
        .clear_i (state_q == FLUSH),
        .tag_i   (w_win_idx),
        .tag_o   (w_head_tag),
        .count_o (w_count),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    // --------------------------------------------------------------- outputs
    // Pass-through paths are forced low while reset is held.
    assign req_ready     = w_grant ? (N_REQ'(1) << w_win_idx) : '0;
    assign add_valid_in  = w_grant;
    assign add_a         = w_add_a;
    assign add_b         = w_add_b;
    assign add_cin       = w_add_cin;
    assign resp_valid    = (w_have && add_valid_out && (state_q != FLUSH) && !flush_req)
                           ? w_head_oh : '0;
    assign resp_sum      = rst ? add_sum : '0;
    assign resp_cout     = rst && add_cout;
    assign add_out_allow = rst && w_out_allow;
    assign add_pause     = ((state_q == DRAIN) && w_have && !w_head_ready) ? '1 : '0;
    assign add_refresh   = (state_q == FLUSH) ? '1 : '0;
    assign busy          = (w_count != '0) || (state_q != RUN);

`ifdef ADDER_ARB_STATS_EN
    logic [15:0] flush_cnt_q;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_grant_cnt
        logic [15:0] cnt_q;
        // Saturating per-requester grant counter.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt_q <= '0;
            end else if (w_grant && (w_win_idx == TAG_W'(gi)) && (cnt_q != 16'hFFFF)) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
        assign grant_cnt[gi*16 +: 16] = cnt_q;
    end

    // FLUSH lasts one cycle, so a FLUSH next-state is always an entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_cnt_q <= '0;
        end else if ((state_d == FLUSH) && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end
    assign flush_cnt = flush_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_adder_pipe_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adder_pipe_arbiter
//  Brief    : Directed self-checking bench for adder_pipe_arbiter with a
//             behavioural 4-stage stallable adder attached.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_adder_pipe_arbiter;

    localparam int W = 32;
    localparam int N = 4;
    localparam int D = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req_valid, req_ready, req_cin, resp_valid, resp_ready;
    logic [N*W-1:0] req_a, req_b;
    logic [W-1:0]   resp_sum;
    logic           resp_cout, drain_req, flush_req, busy;
    logic           add_valid_in, add_cin, add_out_allow, add_valid_out, add_cout;
    logic [W-1:0]   add_a, add_b, add_sum;
    logic [D-1:0]   add_pause, add_refresh;
`ifdef ADDER_ARB_STATS_EN
    logic [N*16-1:0] grant_cnt;
    logic [15:0]     flush_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    adder_pipe_arbiter #(.WIDTH(W), .N_REQ(N), .DEPTH(D), .TAG_W(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_sum(resp_sum), .resp_cout(resp_cout),
        .drain_req(drain_req), .flush_req(flush_req), .busy(busy),
`ifdef ADDER_ARB_STATS_EN
        .grant_cnt(grant_cnt), .flush_cnt(flush_cnt),
`endif
        .add_valid_in(add_valid_in), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_pause(add_pause), .add_refresh(add_refresh), .add_out_allow(add_out_allow),
        .add_valid_out(add_valid_out), .add_sum(add_sum), .add_cout(add_cout)
    );

    // ---------------- behavioural adder: 4 stages, bubble-collapsing stall
    logic [D-1:0] sv, acc, mv;
    logic [W-1:0] ss [D];
    logic         sc [D];
    logic [W:0]   full_sum;

    assign full_sum      = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
    assign add_valid_out = sv[D-1];
    assign add_sum       = ss[D-1];
    assign add_cout      = sc[D-1];

    always_comb begin
        acc = '0;
        mv  = '0;
        acc[D-1] = !add_pause[D-1] && (!sv[D-1] || add_out_allow);
        mv[D-1]  = sv[D-1] && !add_pause[D-1] && add_out_allow;
        for (int k = D - 2; k >= 0; k--) begin
            acc[k] = !add_pause[k] && (!sv[k] || acc[k+1]);
            mv[k]  = sv[k] && !add_pause[k] && acc[k+1];
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < D; k++) begin
                sv[k] <= 1'b0;
                ss[k] <= '0;
                sc[k] <= 1'b0;
            end
        end else begin
            if (add_refresh[0]) begin
                sv[0] <= 1'b0;
            end else if (acc[0]) begin
                sv[0] <= add_valid_in;
                ss[0] <= full_sum[W-1:0];
                sc[0] <= full_sum[W];
            end
            for (int k = 1; k < D; k++) begin
                if (add_refresh[k]) begin
                    sv[k] <= 1'b0;
                end else if (acc[k]) begin
                    sv[k] <= mv[k-1];
                    ss[k] <= ss[k-1];
                    sc[k] <= sc[k-1];
                end
            end
        end
    end

    // ---------------------------------------------------------------- helpers
    task automatic set_slot(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic c);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_cin[i]      = c;
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_cin    = '0;
        resp_ready = '1;
        drain_req  = 1'b0;
        flush_req  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        do_reset();
        rst       = 1'b0;
        req_valid = '1;
        @(negedge clk); #1;
        n_cmp++; if (req_ready !== 4'b0) begin n_bad++; $display("FAIL rst_req_ready got %b want 0000", req_ready); end
        n_cmp++; if (add_valid_in !== 1'b0) begin n_bad++; $display("FAIL rst_valid_in got %b want 0", add_valid_in); end
        n_cmp++; if (add_out_allow !== 1'b0) begin n_bad++; $display("FAIL rst_out_allow got %b want 0", add_out_allow); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
        n_cmp++; if (resp_valid !== 4'b0) begin n_bad++; $display("FAIL rst_resp_valid got %b want 0000", resp_valid); end
        n_cmp++; if ((add_pause !== 4'b0) || (add_refresh !== 4'b0)) begin n_bad++; $display("FAIL rst_pause_refresh got %b/%b want 0000/0000", add_pause, add_refresh); end
        do_reset();
        #1;
        n_cmp++; if (add_out_allow !== 1'b1) begin n_bad++; $display("FAIL idle_out_allow got %b want 1", add_out_allow); end
    endtask

    task automatic test_single();
        do_reset();
        set_slot(0, 32'd18, 32'd13, 1'b0);
        req_valid = 4'b0001;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL single_grant got %b want 0001", req_ready); end
        n_cmp++; if (add_a !== 32'd18) begin n_bad++; $display("FAIL single_add_a got %0d want 18", add_a); end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            req_valid = '0;
            #1;
            if (k == 3) begin
                n_cmp++; if (resp_valid !== 4'b0) begin n_bad++; $display("FAIL single_early got %b want 0000", resp_valid); end
            end
            if (k == 4) begin
                n_cmp++; if (resp_valid !== 4'b0001) begin n_bad++; $display("FAIL single_resp_valid got %b want 0001", resp_valid); end
                n_cmp++; if ({resp_cout, resp_sum} !== {1'b0, 32'd31}) begin n_bad++; $display("FAIL single_sum got %0d/%0d want 0/31", resp_cout, resp_sum); end
            end
        end
    endtask

    task automatic test_fairness();
        int exp_sum [4];
        exp_sum = '{11, 23, 33, 45};
        do_reset();
        for (int i = 0; i < N; i++) begin
            set_slot(i, 32'(10 * (i + 1)), 32'(i + 1), i[0]);
        end
        for (int k = 0; k < 12; k++) begin
            logic [3:0] exp_oh;
            if (k > 0) @(negedge clk);
            req_valid = (k < 8) ? 4'b1111 : 4'b0000;
            #1;
            if (k < 8) begin
                exp_oh = 4'b0001 << (k % 4);
                n_cmp++; if (req_ready !== exp_oh) begin n_bad++; $display("FAIL fair_grant[%0d] got %b want %b", k, req_ready, exp_oh); end
            end
            if (k >= 4) begin
                exp_oh = 4'b0001 << ((k - 4) % 4);
                n_cmp++; if (resp_valid !== exp_oh) begin n_bad++; $display("FAIL fair_resp_valid[%0d] got %b want %b", k, resp_valid, exp_oh); end
                n_cmp++; if (resp_sum !== 32'(exp_sum[(k - 4) % 4])) begin n_bad++; $display("FAIL fair_sum[%0d] got %0d want %0d", k, resp_sum, exp_sum[(k - 4) % 4]); end
            end
        end
    endtask

    task automatic test_back_pressure();
        do_reset();
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) @(negedge clk);
            if (k < 4) set_slot(0, 32'(k + 1), 32'd100, 1'b0);
            else       set_slot(0, 32'd5, 32'd100, 1'b0);
            req_valid  = (k <= 7) ? 4'b0001 : 4'b0000;
            resp_ready = (k >= 7) ? 4'b1111 : 4'b1110;
            #1;
            if (k < 4) begin
                n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL bp_fill_grant[%0d] got %b want 0001", k, req_ready); end
            end else if (k <= 6) begin
                n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL bp_full_grant[%0d] got %b want 0000", k, req_ready); end
                n_cmp++; if (add_out_allow !== 1'b0) begin n_bad++; $display("FAIL bp_out_allow[%0d] got %b want 0", k, add_out_allow); end
                n_cmp++; if ((resp_valid !== 4'b0001) || (resp_sum !== 32'd101)) begin n_bad++; $display("FAIL bp_hold[%0d] got %b/%0d want 0001/101", k, resp_valid, resp_sum); end
            end else if (k <= 11) begin
                if (k == 7) begin
                    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL bp_resume_grant got %b want 0001", req_ready); end
                end
                n_cmp++; if ((resp_valid !== 4'b0001) || (resp_sum !== 32'(94 + k))) begin n_bad++; $display("FAIL bp_drain[%0d] got %b/%0d want 0001/%0d", k, resp_valid, resp_sum, 94 + k); end
            end else begin
                n_cmp++; if ((resp_valid !== 4'b0000) || (busy !== 1'b0)) begin n_bad++; $display("FAIL bp_empty got %b/%b want 0000/0", resp_valid, busy); end
            end
        end
    endtask

    task automatic test_carry();
        do_reset();
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 0) set_slot(2, 32'hFFFF_FFFF, 32'd1, 1'b0);
            else        set_slot(2, 32'd0, 32'd0, 1'b1);
            req_valid = (k < 2) ? 4'b0100 : 4'b0000;
            #1;
            if (k == 4) begin
                n_cmp++; if ((resp_valid !== 4'b0100) || ({resp_cout, resp_sum} !== {1'b1, 32'd0})) begin n_bad++; $display("FAIL carry_out got %b %0d/%h want 0100 1/00000000", resp_valid, resp_cout, resp_sum); end
            end
            if (k == 5) begin
                n_cmp++; if ((resp_valid !== 4'b0100) || ({resp_cout, resp_sum} !== {1'b0, 32'd1})) begin n_bad++; $display("FAIL carry_in got %b %0d/%h want 0100 0/00000001", resp_valid, resp_cout, resp_sum); end
            end
        end
    endtask

    task automatic test_flush();
        do_reset();
        set_slot(1, 32'd7, 32'd8, 1'b0);
        set_slot(3, 32'd1000, 32'd234, 1'b1);
        for (int k = 0; k <= 9; k++) begin
            if (k > 0) @(negedge clk);
            flush_req = (k == 3);
            if (k < 3)                 req_valid = 4'b0010;
            else if (k == 3 || k == 5) req_valid = 4'b1000;
            else                       req_valid = 4'b0000;
            #1;
            case (k)
                3: begin
                    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL flush_blocks_grant got %b want 0000", req_ready); end
                    n_cmp++; if ((add_refresh !== 4'b0000) || (busy !== 1'b1)) begin n_bad++; $display("FAIL flush_pre got %b/%b want 0000/1", add_refresh, busy); end
                end
                4: begin
                    n_cmp++; if (add_refresh !== 4'b1111) begin n_bad++; $display("FAIL flush_refresh got %b want 1111", add_refresh); end
                    n_cmp++; if ((resp_valid !== 4'b0000) || (add_valid_in !== 1'b0)) begin n_bad++; $display("FAIL flush_quiet got %b/%b want 0000/0", resp_valid, add_valid_in); end
                end
                5: begin
                    n_cmp++; if ((add_refresh !== 4'b0000) || (busy !== 1'b0)) begin n_bad++; $display("FAIL flush_after got %b/%b want 0000/0", add_refresh, busy); end
                    n_cmp++; if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL flush_new_grant got %b want 1000", req_ready); end
                end
                9: begin
                    n_cmp++; if ((resp_valid !== 4'b1000) || ({resp_cout, resp_sum} !== {1'b0, 32'd1235})) begin n_bad++; $display("FAIL flush_new_sum got %b %0d/%0d want 1000 0/1235", resp_valid, resp_cout, resp_sum); end
                end
                default: begin
                    if (k >= 6) begin
                        n_cmp++; if (resp_valid !== 4'b0000) begin n_bad++; $display("FAIL flush_stale[%0d] got %b want 0000", k, resp_valid); end
                    end
                end
            endcase
        end
    endtask

    task automatic test_drain_reset();
        do_reset();
        for (int k = 0; k <= 9; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 0) set_slot(0, 32'd1, 32'd2, 1'b0);
            if (k == 1) set_slot(0, 32'd3, 32'd4, 1'b0);
            if (k >= 3) set_slot(1, 32'd50, 32'd60, 1'b0);
            if (k < 2)                 req_valid = 4'b0001;
            else if (k == 2 || k == 9) req_valid = 4'b0000;
            else                       req_valid = 4'b0010;
            drain_req  = (k == 2);
            resp_ready = (k == 4) ? 4'b1110 : 4'b1111;
            #1;
            case (k)
                3: begin
                    n_cmp++; if ((req_ready !== 4'b0000) || (add_valid_in !== 1'b0) || (busy !== 1'b1)) begin n_bad++; $display("FAIL drain_no_issue got %b/%b/%b want 0000/0/1", req_ready, add_valid_in, busy); end
                end
                4: begin
                    n_cmp++; if (add_pause !== 4'b1111) begin n_bad++; $display("FAIL drain_pause got %b want 1111", add_pause); end
                    n_cmp++; if ((resp_valid !== 4'b0001) || (add_out_allow !== 1'b0)) begin n_bad++; $display("FAIL drain_hold got %b/%b want 0001/0", resp_valid, add_out_allow); end
                end
                5: begin
                    n_cmp++; if ((add_pause !== 4'b0000) || (resp_valid !== 4'b0001) || (resp_sum !== 32'd3)) begin n_bad++; $display("FAIL drain_resp0 got %b/%b/%0d want 0000/0001/3", add_pause, resp_valid, resp_sum); end
                end
                6: begin
                    n_cmp++; if ((resp_valid !== 4'b0001) || (resp_sum !== 32'd7)) begin n_bad++; $display("FAIL drain_resp1 got %b/%0d want 0001/7", resp_valid, resp_sum); end
                end
                7: begin
                    n_cmp++; if ((busy !== 1'b1) || (req_ready !== 4'b0000)) begin n_bad++; $display("FAIL drain_last got %b/%b want 1/0000", busy, req_ready); end
                end
                8: begin
                    n_cmp++; if ((busy !== 1'b0) || (req_ready !== 4'b0010)) begin n_bad++; $display("FAIL drain_back_run got %b/%b want 0/0010", busy, req_ready); end
                end
                9: begin
                    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL inflight_busy got %b want 1", busy); end
                end
                default: ;
            endcase
        end
        rst       = 1'b0;
        req_valid = 4'b1111;
        #1;
        n_cmp++; if ((busy !== 1'b0) || (req_ready !== 4'b0000) || (resp_valid !== 4'b0000)) begin n_bad++; $display("FAIL midrst_ctrl got %b/%b/%b want 0/0000/0000", busy, req_ready, resp_valid); end
        n_cmp++; if ((add_valid_in !== 1'b0) || (add_out_allow !== 1'b0) || (resp_sum !== 32'd0)) begin n_bad++; $display("FAIL midrst_data got %b/%b/%h want 0/0/00000000", add_valid_in, add_out_allow, resp_sum); end
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 4'b0000;
        for (int m = 0; m < 6; m++) begin
            @(negedge clk); #1;
            n_cmp++; if ((resp_valid !== 4'b0000) || (busy !== 1'b0)) begin n_bad++; $display("FAIL orphan[%0d] got %b/%b want 0000/0", m, resp_valid, busy); end
        end
    endtask

    initial begin
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_cin    = '0;
        resp_ready = '1;
        drain_req  = 1'b0;
        flush_req  = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_back_pressure();
        test_carry();
        test_flush();
        test_drain_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adder_pipe_arbiter.md
Name: adder_pipe_arbiter

Overview:
- Shares one 4-stage stallable pipeline adder between N_REQ requesters.
- Round-robin arbitration on request valid/ready handshakes, driving the adder's valid_in/data/c_in.
- Tracks the owner tag of every in-flight operation in an in-order tag FIFO and routes each result back to its owner's response channel.
- Sequences the adder's pause/refresh vectors for drain and flush operations; sits directly between the requester fabric and the adder instance.

Parameters:
- WIDTH, 32, operand/sum width.
- N_REQ, 4, number of requesters (2..8).
- DEPTH, 4, adder pipeline stages; also the in-flight limit and tag FIFO depth.
- TAG_W, 2, tag width; must satisfy 2**TAG_W >= N_REQ.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-requester operation valid.
- req_ready  out  N_REQ  per-requester grant; one-hot or zero.
- req_a  in  N_REQ*WIDTH  packed operand A; slot i is bits [i*WIDTH +: WIDTH].
- req_b  in  N_REQ*WIDTH  packed operand B.
- req_cin  in  N_REQ  per-requester carry-in.
- resp_valid  out  N_REQ  result valid; one-hot or zero.
- resp_ready  in  N_REQ  per-requester result accept.
- resp_sum  out  WIDTH  result sum, shared by all requesters.
- resp_cout  out  1  result carry-out, shared.
- drain_req  in  1  level; stop issuing and wait until empty.
- flush_req  in  1  pulse; discard all in-flight operations.
- busy  out  1  tag FIFO not empty, or state != RUN.
- add_valid_in  out  1  to adder valid_in.
- add_a, add_b  out  WIDTH  to adder data_a/data_b.
- add_cin  out  1  to adder c_in.
- add_pause  out  DEPTH  to adder pause.
- add_refresh  out  DEPTH  to adder refresh.
- add_out_allow  out  1  to adder out_allow.
- add_valid_out  in  1  from adder vaild_out.
- add_sum  in  WIDTH  from adder sum_out.
- add_cout  in  1  from adder c_out.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=RUN, rr_ptr=0, FIFO count=0, head/tail=0.
  - All outputs 0, including add_pause=0, add_refresh=0, busy=0.
- Adder contract: the adder accepts valid_in every cycle in which fewer than DEPTH ops are in flight. Results emerge in issue order, DEPTH cycles after issue when unstalled.
- issue_ok = (state==RUN) && (count<DEPTH || pop) && !flush_req.
- Arbitration:
  - The winner is the first i with req_valid[i], searching from rr_ptr upward with wrap.
  - When issue_ok, req_ready[winner]=1 and every other req_ready bit is 0.
  - req_ready is combinational from req_valid, rr_ptr and state.
- Grant (req_valid & req_ready):
  - add_valid_in=1, with add_a/add_b/add_cin muxed from the winner's slot.
  - Push the winner's tag into the FIFO.
  - rr_ptr <= (winner+1) mod N_REQ.
  - With no grant, rr_ptr holds and add_valid_in=0.
- Return path, with h = tag at the FIFO head:
  - resp_valid[h] = add_valid_out, and only when count>0.
  - resp_sum/resp_cout pass through from add_sum/add_cout.
  - add_out_allow = resp_ready[h] when count>0, else 1.
  - pop = add_valid_out && add_out_allow.
  - Push and pop in the same cycle leave count unchanged; a push is allowed at count==DEPTH only when a pop occurs in that cycle.
- States:
  - RUN: normal operation.
    - flush_req=1 -> FLUSH (takes priority over drain_req).
    - drain_req=1 -> DRAIN.
  - DRAIN: no issue; responses continue.
    - count==0 -> RUN.
    - flush_req=1 -> FLUSH.
  - FLUSH: lasts exactly one cycle.
    - add_refresh = all ones; add_pause = 0.
    - The FIFO is cleared (count=0, head=tail), resp_valid=0, no issue.
    - Next state RUN.
- add_pause is all ones in DRAIN while resp_ready[h]==0 and count>0, which freezes the pipe. It is 0 in every other case.
- A flush_req arriving in the same cycle as a would-be grant blocks that grant (req_ready=0). Any result presented in that cycle is discarded.
- A mid-operation reset drops all in-flight tags. The adder is reset by the same rst, so no orphan result can be routed.

Optional Feature:
- Macro ADDER_ARB_STATS_EN.
- Defined:
  - Adds output grant_cnt (N_REQ*16 packed): per-requester 16-bit saturating grant counters.
  - Adds output flush_cnt (16): flushes executed.
  - All counters reset to 0.
  - A counter increments on a grant or on FLUSH entry, and saturates at 16'hFFFF.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package adder_arb_pkg holds:
  - state encoding: RUN=2'd0, DRAIN=2'd1, FLUSH=2'd2;
  - default constants for WIDTH/DEPTH/N_REQ;
  - function clog2.
- One natural sub-module, tag_fifo: synchronous, DEPTH entries × TAG_W bits, with push/pop/clear and count/full/empty outputs.
- Round-robin selection stays inline.

Test Plan:
- Single requester: req0 sends a=18, b=13, cin=0, out_allow path ready.
  - req_ready[0] on cycle 0.
  - resp_valid[0]=1 with resp_sum=31, resp_cout=0 exactly DEPTH cycles later.
- Fairness: all 4 requesters hold req_valid for 8 cycles.
  - Grant order 0,1,2,3,0,1,2,3.
  - Each response arrives on its own resp_valid bit, in issue order, with correct sums.
- Back-pressure:
  - resp_ready[0]=0 for 3 cycles with 4 ops in flight -> req_ready stays 0 (count==DEPTH) and add_out_allow=0.
  - Releasing resp_ready[0] resumes the ops with no loss or duplication.
- Carry: a=32'hFFFFFFFF, b=1, cin=0 -> resp_sum=0, resp_cout=1. The cin=1 case with a=b=0 -> resp_sum=1.
- Flush: pulse flush_req with 3 ops in flight.
  - add_refresh=4'b1111 for exactly one cycle.
  - No resp_valid for the flushed ops; busy=0 next cycle.
  - A new op afterwards returns its correct sum.
- Drain plus reset:
  - drain_req=1 -> no grants, busy falls once count reaches 0, and the FSM returns to RUN.
  - Asserting rst=0 mid-flight clears all outputs immediately.
